// File: rtl/io_wait_state_generator.sv
// rtl/io_wait_state_generator.sv - I/O channel ready generator for I/O and slow-memory cycles
module io_wait_state_generator #(
    parameter logic [3:0] IO_WAIT_CYCLES  = 4'd4,
    parameter logic [3:0] MEM_WAIT_CYCLES = 4'd1,
    parameter logic [3:0] SLOW_MEM_SEG    = 4'hB,
    parameter logic [7:0] TIMEOUT_CYCLES  = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    input  logic        dma_cycle,
    input  logic        device_not_ready,
    output logic        io_channel_ready,
    output logic        wait_active,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE} state_t;

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic [7:0] to_cnt, to_cnt_next;
    logic       ready_next, timeout_next;
    logic       cmd_io, cmd_mem, cmd, cmd_d, start;
    logic [3:0] load_value;
    logic       unused_address_bits;

    assign cmd_io     = ~io_read_n | ~io_write_n;
    assign cmd_mem    = (~memory_read_n | ~memory_write_n) & (address[19:16] == SLOW_MEM_SEG);
    assign cmd        = cmd_io | cmd_mem;
    assign start      = cmd & ~cmd_d;
    assign load_value = cmd_io ? IO_WAIT_CYCLES : MEM_WAIT_CYCLES;
    assign unused_address_bits = ^address[15:0];

    // Dropping the command always wins, so an aborted cycle never reports a timeout.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        to_cnt_next   = to_cnt;
        ready_next    = 1'b1;
        timeout_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (dma_cycle || (load_value == 4'd0)) begin
                        state_next = S_DONE;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = load_value;
                        ready_next    = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                if (!cmd) begin
                    state_next = S_IDLE;
                end else if (wait_cnt <= 4'd1) begin
                    if (device_not_ready) begin
                        state_next  = S_HOLD;
                        to_cnt_next = 8'd0;
                        ready_next  = 1'b0;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    ready_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (!cmd) begin
                    state_next = S_IDLE;
                end else if (!device_not_ready) begin
                    state_next = S_DONE;
                end else if (to_cnt == (TIMEOUT_CYCLES - 8'd1)) begin
                    state_next   = S_DONE;
                    timeout_next = 1'b1;
                end else begin
                    ready_next = 1'b0;
                    if (to_cnt != 8'hFF) begin
                        to_cnt_next = to_cnt + 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (!cmd) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            wait_cnt         <= 4'd0;
            to_cnt           <= 8'd0;
            cmd_d            <= 1'b0;
            io_channel_ready <= 1'b1;
            wait_active      <= 1'b0;
            bus_timeout      <= 1'b0;
        end else begin
            state            <= state_next;
            wait_cnt         <= wait_cnt_next;
            to_cnt           <= to_cnt_next;
            cmd_d            <= cmd;
            io_channel_ready <= ready_next;
            wait_active      <= (state_next == S_WAIT) || (state_next == S_HOLD);
            bus_timeout      <= timeout_next;
        end
    end

endmodule
